// File: rtl/fp_cmp_stream_adapter_pkg.sv
// Shared FP constants and operand classification for the compare stream adapter.
package fp_cmp_pkg;

    localparam logic [7:0] FP_EXP_ONES  = 8'hFF;
    localparam int         FP_QUIET_BIT = 22;

    // Signalling NaN: all-ones exponent, quiet bit clear, non-zero payload.
    function automatic logic is_snan(input logic [31:0] x);
        return (x[30:23] == FP_EXP_ONES) && !x[FP_QUIET_BIT] && (x[21:0] != 22'd0);
    endfunction

endpackage

// File: rtl/fp_cmp_stream_adapter_if.sv
// Request/result stream bundle between FP issue logic and the compare adapter.
interface fp_cmp_stream_adapter_if #(
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic             out_q;
    logic             out_nv;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_q, out_nv, out_tag
    );

    modport slave (
        input  in_valid, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_q, out_nv, out_tag
    );
endinterface

// File: rtl/fp_cmp_stream_adapter_fifo.sv
// Result FIFO: register-array storage, wrapping pointers; the caller guarantees no overflow.
module fp_cmp_result_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 7
) (
    input  logic         clk,
    input  logic         areset,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic         rd_valid,
    output logic [W-1:0] rd_data
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] occ;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= nxt(wr_ptr);
            end
            if (rd_en) rd_ptr <= nxt(rd_ptr);
            case ({wr_en, rd_en})
                2'b10:   occ <= occ + CW'(1);
                2'b01:   occ <= occ - CW'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Head entry comes straight from storage flops, so no input-to-output path.
    assign rd_valid = (occ != '0);
    assign rd_data  = mem[rd_ptr];

endmodule

// File: rtl/fp_cmp_stream_adapter.sv
// Valid/ready wrapper around a fixed-latency FP equality comparator with credit-based result FIFO.
module fp_cmp_stream_adapter
    import fp_cmp_pkg::*;
#(
    parameter int LATENCY = 1,
    parameter int TAG_W   = 5,
    parameter int DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    areset,
    fp_cmp_stream_adapter_if.slave  bus,
    output logic [31:0]             cmp_a,
    output logic [31:0]             cmp_b,
    input  logic                    cmp_q
);
    localparam int            CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef struct packed {
        logic             nv;
        logic [TAG_W-1:0] tag;
    } meta_t;

    typedef struct packed {
        logic             q;
        logic             nv;
        logic [TAG_W-1:0] tag;
    } res_t;

    if (LATENCY < 1 || DEPTH < LATENCY + 1) begin : g_bad_cfg
        $error("fp_cmp_stream_adapter: need LATENCY >= 1 and DEPTH >= LATENCY+1");
    end

    logic              accept, pop;
    logic [CW-1:0]     count;
    logic [LATENCY-1:0] vld_pipe;
    meta_t [LATENCY-1:0] meta_pipe;
    res_t              wr_res, rd_res;
    logic              rd_valid;

    assign cmp_a  = bus.in_a;
    assign cmp_b  = bus.in_b;
    assign accept = bus.in_valid && bus.in_ready;
    assign pop    = rd_valid && bus.out_ready;

    // Credits cover in-flight ops plus queued results, so the FIFO can never overflow.
    assign bus.in_ready = areset && (count < DEPTH_C);

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            count <= '0;
        end else begin
            case ({accept, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            vld_pipe  <= '0;
            meta_pipe <= '0;
        end else begin
            vld_pipe[0]  <= accept;
            meta_pipe[0] <= '{nv: is_snan(bus.in_a) || is_snan(bus.in_b), tag: bus.in_tag};
            for (int i = 1; i < LATENCY; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                meta_pipe[i] <= meta_pipe[i-1];
            end
        end
    end

    // cmp_q is only meaningful in the cycle the matching op reaches the last stage.
    assign wr_res = '{q: cmp_q, nv: meta_pipe[LATENCY-1].nv, tag: meta_pipe[LATENCY-1].tag};

    fp_cmp_result_fifo #(
        .DEPTH (DEPTH),
        .W     (TAG_W + 2)
    ) u_fifo (
        .clk      (clk),
        .areset   (areset),
        .wr_en    (vld_pipe[LATENCY-1]),
        .wr_data  (wr_res),
        .rd_en    (pop),
        .rd_valid (rd_valid),
        .rd_data  (rd_res)
    );

    assign bus.out_valid = rd_valid;
    assign bus.out_q     = rd_res.q;
    assign bus.out_nv    = rd_res.nv;
    assign bus.out_tag   = rd_res.tag;

endmodule

// File: tb/tb_fp_cmp_stream_adapter.sv
// Scoreboard bench for fp_cmp_stream_adapter (LATENCY=1, DEPTH=4) with a behavioural comparator.
module tb_fp_cmp_stream_adapter;
    localparam int TAG_W = 5;

    logic        clk = 1'b0;
    logic        areset = 1'b0;
    logic [31:0] cmp_a, cmp_b;
    logic        cmp_q = 1'b0;

    int checks = 0, failures = 0, n_out = 0, cyc = 0;
    logic [TAG_W+1:0] exp_q[$];
    int               pop_cyc[$];

    fp_cmp_stream_adapter_if #(.TAG_W(TAG_W)) bus ();

    fp_cmp_stream_adapter #(.LATENCY(1), .TAG_W(TAG_W), .DEPTH(4)) dut (
        .clk    (clk),
        .areset (areset),
        .bus    (bus.slave),
        .cmp_a  (cmp_a),
        .cmp_b  (cmp_b),
        .cmp_q  (cmp_q)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    // IEEE equality: NaN never equal, +0 == -0.
    always @(posedge clk)
        cmp_q <= !is_nan(cmp_a) && !is_nan(cmp_b) &&
                 ((cmp_a == cmp_b) || (cmp_a[30:0] == 31'd0 && cmp_b[30:0] == 31'd0));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: consume a result whenever the handshake will complete on the coming edge.
    always begin
        logic [TAG_W+1:0] e;
        @(negedge clk); #1;
        if (areset && bus.out_valid && bus.out_ready) begin
            n_out++;
            pop_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result: tag %0d q %0b with empty scoreboard", bus.out_tag, bus.out_q);
            end else begin
                e = exp_q.pop_front();
                chk("result", 32'({bus.out_q, bus.out_nv, bus.out_tag}), 32'(e));
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] tag,
                        input logic q, input logic nv, output int waits);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_tag   = tag;
        waits        = 0;
        #1;
        while (!bus.in_ready && waits < 50) begin
            @(negedge clk); #1;
            waits++;
        end
        if (bus.in_ready) exp_q.push_back({q, nv, tag});
        else begin
            checks++;
            failures++;
            $display("FAIL send_timeout: tag %0d not accepted within 50 cycles", tag);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    logic [31:0] va [6] = '{32'h7F800001, 32'h7FC00000, 32'h00000000, 32'h3F800000, 32'h7F800000, 32'h7F800000};
    logic [31:0] vb [6] = '{32'h3F800000, 32'h7FC00000, 32'h80000000, 32'hFF800001, 32'h7F800000, 32'h7FC00001};
    logic        vq [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic        vnv[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    initial begin
        int w, acc, n0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_fields", 32'({bus.out_q, bus.out_nv, bus.out_tag}), 32'd0);
        @(negedge clk);
        areset = 1'b1;
        #1;
        chk("rel_in_ready", 32'(bus.in_ready), 32'd1);

        // 1: single request, latency
        send(32'h3F800000, 32'h3F800000, 5'd3, 1'b1, 1'b0, w);
        idle(); #1;
        chk("t1_valid_cycle1", 32'(bus.out_valid), 32'd0);
        @(negedge clk); #1;
        chk("t1_valid_cycle2", 32'(bus.out_valid), 32'd1);
        repeat (3) @(negedge clk);

        // 2: eight back-to-back requests
        pop_cyc.delete();
        for (int i = 0; i < 8; i++) begin
            send(32'h40000000 + 32'(i), (i % 2 == 1) ? 32'h40000000 + 32'(i) : (32'h40000000 + 32'(i)) ^ 32'd1,
                 5'(i), (i % 2 == 1), 1'b0, w);
            chk("t2_no_stall", 32'(w), 32'd0);
        end
        idle();
        repeat (4) @(negedge clk);
        #1;
        chk("t2_pop_count", 32'(pop_cyc.size()), 32'd8);
        for (int i = 1; i < 8 && i < pop_cyc.size(); i++)
            chk("t2_one_per_cycle", 32'(pop_cyc[i] - pop_cyc[i-1]), 32'd1);

        // 3: backpressure fills credits
        @(negedge clk);
        bus.out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_a     = 32'h3F800000;
            bus.in_b     = 32'h3F800000;
            bus.in_tag   = 5'(8 + acc);
            #1;
            if (bus.in_ready) begin
                exp_q.push_back({1'b1, 1'b0, 5'(8 + acc)});
                acc++;
            end
        end
        chk("t3_accepts", 32'(acc), 32'd4);
        chk("t3_in_ready_low", 32'(bus.in_ready), 32'd0);
        chk("t3_out_valid_held", 32'(bus.out_valid), 32'd1);
        n0 = n_out;
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        chk("t3_drained", 32'(n_out - n0), 32'd4);
        chk("t3_sb_empty", 32'(exp_q.size()), 32'd0);

        // 4: NaN / signed-zero corner operands
        for (int i = 0; i < 6; i++) send(va[i], vb[i], 5'(12 + i), vq[i], vnv[i], w);
        idle();
        repeat (4) @(negedge clk);

        // 5: reset with ops in flight
        @(negedge clk);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(32'h3F800000, 32'h3F800000, 5'(20 + i), 1'b1, 1'b0, w);
        @(negedge clk);
        bus.in_valid = 1'b0;
        areset       = 1'b0;
        #1;
        chk("t5_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("t5_rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("t5_rst_fields", 32'({bus.out_q, bus.out_nv, bus.out_tag}), 32'd0);
        exp_q.delete();
        @(negedge clk);
        areset        = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        chk("t5_rel_in_ready", 32'(bus.in_ready), 32'd1);
        chk("t5_rel_out_valid", 32'(bus.out_valid), 32'd0);
        n0 = n_out;
        repeat (4) @(negedge clk);
        #1;
        chk("t5_no_stale_results", 32'(n_out - n0), 32'd0);

        // 6: full FIFO, simultaneous pop and request, then sustained traffic
        @(negedge clk);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(32'h3F800000, 32'h3F800000, 5'(24 + i), 1'b1, 1'b0, w);
            chk("t6_fill_no_stall", 32'(w), 32'd0);
        end
        @(negedge clk);
        bus.in_tag    = 5'd28;
        bus.out_ready = 1'b1;
        #1;
        chk("t6_full_pop_only", 32'(bus.in_ready), 32'd0);
        for (int k = 0; k < 6; k++) begin
            send(32'h3F800000, (k % 2 == 0) ? 32'h3F800000 : 32'h40000000, 5'(28 + k),
                 (k % 2 == 0), 1'b0, w);
            chk("t6_sustained_no_stall", 32'(w), 32'd0);
        end
        idle();
        repeat (8) @(negedge clk);
        #1;
        chk("final_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
